// File: rtl/alici_if.sv
// Handshake/data bundle between a chunk transmitter and the alici receiver.
interface alici_if #(
  parameter int N = 12
);
  logic         basla;
  logic         mod;
  logic         gecerli;
  logic [N-1:0] gelen_veri;
  logic [N-1:0] cikan_veri;
  logic         bitti;
  logic         hata;
  logic         mesgul;

  modport master (
    output basla, mod, gecerli, gelen_veri,
    input  cikan_veri, bitti, hata, mesgul
  );

  modport slave (
    input  basla, mod, gecerli, gelen_veri,
    output cikan_veri, bitti, hata, mesgul
  );
endinterface

// File: rtl/alici.sv
// Receiver: takes a parallel word or N/3 MSB-first 3-bit chunks, rebuilds the word,
// pulses bitti on completion and hata when a chunk stream stalls too long.
module alici #(
  parameter int N           = 12,
  parameter int ZAMAN_ASIMI = 8
) (
  input  logic   clk,
  input  logic   rst,
  alici_if.slave bus
);
  localparam int CNT_W = $clog2(N/3 + 1);
  localparam int GAP_W = $clog2(ZAMAN_ASIMI + 1);
  localparam logic [CNT_W-1:0] SON_PARCA = CNT_W'(N/3 - 1);
  localparam logic [GAP_W-1:0] SON_BOSLUK = GAP_W'(ZAMAN_ASIMI - 1);

  typedef enum logic {BOS, ALIM} state_e;

  state_e           state_q;
  logic [N-1:0]     shift_q;
  logic [CNT_W-1:0] cnt_q;
  logic [GAP_W-1:0] gap_q;
  logic [N-1:0]     cikan_q;
  logic             bitti_q;
  logic             hata_q;
  logic             mesgul_q;
  logic [N-1:0]     shift_d;

  // Shift-then-OR form stays valid for N = 3, where shift[N-4:0] would be empty.
  always_comb begin
    shift_d = (shift_q << 3) | N'(bus.gelen_veri[2:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BOS;
      shift_q  <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      cikan_q  <= '0;
      bitti_q  <= 1'b0;
      hata_q   <= 1'b0;
      mesgul_q <= 1'b0;
    end else begin
      bitti_q <= 1'b0;
      hata_q  <= 1'b0;
      if (bus.basla) begin
        // Start or restart; an aborted reception raises no pulse.
        shift_q <= '0;
        cnt_q   <= '0;
        gap_q   <= '0;
        if (bus.mod) begin
          state_q  <= ALIM;
          mesgul_q <= 1'b1;
        end else begin
          cikan_q  <= bus.gelen_veri;
          bitti_q  <= 1'b1;
          state_q  <= BOS;
          mesgul_q <= 1'b0;
        end
      end else if (state_q == ALIM) begin
        if (bus.gecerli) begin
          gap_q <= '0;
          if (cnt_q == SON_PARCA) begin
            cikan_q  <= shift_d;
            bitti_q  <= 1'b1;
            shift_q  <= '0;
            cnt_q    <= '0;
            state_q  <= BOS;
            mesgul_q <= 1'b0;
          end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_q + 1'b1;
          end
        end else if (gap_q == SON_BOSLUK) begin
          hata_q   <= 1'b1;
          shift_q  <= '0;
          cnt_q    <= '0;
          gap_q    <= '0;
          state_q  <= BOS;
          mesgul_q <= 1'b0;
        end else begin
          gap_q <= gap_q + 1'b1;
        end
      end
    end
  end

  assign bus.cikan_veri = cikan_q;
  assign bus.bitti      = bitti_q;
  assign bus.hata       = hata_q;
  assign bus.mesgul     = mesgul_q;
endmodule

// File: tb/tb_alici.sv
// Scoreboard bench for alici: expected words are queued at stimulus time and
// popped whenever the receiver pulses bitti.
module tb_alici;
  localparam int N = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   bitti_cnt = 0;
  int   hata_cnt = 0;
  int   push_cnt = 0;
  logic [N-1:0] sb[$];

  alici_if #(.N(N)) bus();

  alici #(.N(N), .ZAMAN_ASIMI(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [N-1:0] w);
    sb.push_back(w);
    push_cnt++;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.bitti) begin
        bitti_cnt++;
        if (sb.size() == 0) chk("spurious_bitti", 32'd1, 32'd0);
        else chk("word", 32'(bus.cikan_veri), 32'(sb.pop_front()));
      end
      if (bus.hata) hata_cnt++;
      if (bus.bitti || bus.hata) chk("bitti_hata_excl", 32'(bus.bitti & bus.hata), 32'd0);
    end
  end

  // Mode-1 word transfer; strobe_on_start puts a junk chunk in the basla cycle.
  task automatic send_word(input logic [N-1:0] w, input int gap, input bit strobe_on_start);
    bus.basla      = 1'b1;
    bus.mod        = 1'b1;
    bus.gecerli    = strobe_on_start;
    bus.gelen_veri = '1;
    push(w);
    step();
    bus.basla   = 1'b0;
    bus.gecerli = 1'b0;
    for (int unsigned i = 0; i < N/3; i++) begin
      repeat (gap) step();
      bus.gecerli    = 1'b1;
      bus.gelen_veri = N'(w >> (3 * (N/3 - 1 - i)));
      bus.gelen_veri[N-1:3] = '1;
      step();
      bus.gecerli = 1'b0;
    end
  endtask

  initial begin
    int b0, h0;
    bus.basla = 1'b0; bus.mod = 1'b0; bus.gecerli = 1'b0; bus.gelen_veri = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_cikan", 32'(bus.cikan_veri), 32'd0);
    chk("rst_bitti", 32'(bus.bitti), 32'd0);
    chk("rst_hata", 32'(bus.hata), 32'd0);
    chk("rst_mesgul", 32'(bus.mesgul), 32'd0);

    // Mode 0 capture
    bus.basla = 1'b1; bus.mod = 1'b0; bus.gelen_veri = 12'b011100010110;
    push(12'b011100010110);
    step();
    bus.basla = 1'b0; bus.gelen_veri = '0;
    chk("m0_bitti", 32'(bus.bitti), 32'd1);
    chk("m0_cikan", 32'(bus.cikan_veri), 32'b011100010110);
    step();
    chk("m0_bitti_low", 32'(bus.bitti), 32'd0);
    chk("m0_hold", 32'(bus.cikan_veri), 32'b011100010110);

    // Mode 1 back-to-back with mesgul tracking
    bus.basla = 1'b1; bus.mod = 1'b1;
    push(12'b011100010110);
    step();
    bus.basla = 1'b0;
    chk("m1_mesgul_start", 32'(bus.mesgul), 32'd1);
    for (int unsigned i = 0; i < 4; i++) begin
      logic [11:0] w;
      w = 12'b011100010110;
      bus.gecerli = 1'b1;
      bus.gelen_veri = 12'(w >> (3 * (3 - i)));
      step();
      if (i < 3) chk("m1_mesgul", 32'(bus.mesgul), 32'd1);
      if (i < 3) chk("m1_no_bitti", 32'(bus.bitti), 32'd0);
    end
    bus.gecerli = 1'b0;
    chk("m1_bitti", 32'(bus.bitti), 32'd1);
    chk("m1_cikan", 32'(bus.cikan_veri), 32'b011100010110);
    chk("m1_mesgul_end", 32'(bus.mesgul), 32'd0);
    step();

    // Gaps of two idle cycles, plus a strobe in the basla cycle that must be ignored
    b0 = bitti_cnt; h0 = hata_cnt;
    send_word(12'b000111010101, 2, 1'b1);
    chk("gap_cikan", 32'(bus.cikan_veri), 32'b000111010101);
    step(); step();
    chk("gap_one_bitti", 32'(bitti_cnt - b0), 32'd1);
    chk("gap_no_hata", 32'(hata_cnt - h0), 32'd0);

    // Timeout after a completed word
    bus.basla = 1'b1; bus.mod = 1'b0; bus.gelen_veri = 12'b110010101011;
    push(12'b110010101011);
    step();
    bus.basla = 1'b1; bus.mod = 1'b1;
    step();
    bus.basla = 1'b0;
    bus.gecerli = 1'b1; bus.gelen_veri = 12'd5; step();
    bus.gelen_veri = 12'd2; step();
    bus.gecerli = 1'b0;
    b0 = bitti_cnt; h0 = hata_cnt;
    repeat (7) step();
    chk("to_hata_early", 32'(bus.hata), 32'd0);
    chk("to_mesgul_wait", 32'(bus.mesgul), 32'd1);
    step();
    chk("to_hata", 32'(bus.hata), 32'd1);
    chk("to_mesgul", 32'(bus.mesgul), 32'd0);
    chk("to_cikan", 32'(bus.cikan_veri), 32'b110010101011);
    step();
    chk("to_hata_pulse", 32'(bus.hata), 32'd0);
    chk("to_hata_cnt", 32'(hata_cnt - h0), 32'd1);
    chk("to_no_bitti", 32'(bitti_cnt - b0), 32'd0);

    // Reset mid-reception
    bus.basla = 1'b1; bus.mod = 1'b1; step();
    bus.basla = 1'b0;
    bus.gecerli = 1'b1; bus.gelen_veri = 12'b101; step();
    bus.gelen_veri = 12'b010; step();
    bus.gecerli = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    chk("mrst_cikan", 32'(bus.cikan_veri), 32'd0);
    chk("mrst_mesgul", 32'(bus.mesgul), 32'd0);
    chk("mrst_bitti", 32'(bus.bitti), 32'd0);
    chk("mrst_hata", 32'(bus.hata), 32'd0);
    b0 = bitti_cnt;
    send_word(12'hFFF, 0, 1'b0);
    chk("mrst_final", 32'(bus.cikan_veri), 32'hFFF);
    step(); step();
    chk("mrst_one_bitti", 32'(bitti_cnt - b0), 32'd1);

    // Restart with basla over gecerli
    h0 = hata_cnt;
    bus.basla = 1'b1; bus.mod = 1'b1; step();
    bus.basla = 1'b0;
    bus.gecerli = 1'b1; bus.gelen_veri = 12'b001; step();
    bus.basla = 1'b1; bus.mod = 1'b0; bus.gelen_veri = 12'hABC;
    push(12'hABC);
    step();
    bus.basla = 1'b0; bus.gecerli = 1'b0;
    chk("rs_bitti", 32'(bus.bitti), 32'd1);
    chk("rs_cikan", 32'(bus.cikan_veri), 32'hABC);
    chk("rs_mesgul", 32'(bus.mesgul), 32'd0);
    // gecerli in BOS without basla is ignored
    bus.gecerli = 1'b1; bus.gelen_veri = 12'd7;
    repeat (12) step();
    bus.gecerli = 1'b0;
    chk("rs_no_hata", 32'(hata_cnt - h0), 32'd0);
    chk("rs_idle_mesgul", 32'(bus.mesgul), 32'd0);
    chk("rs_idle_cikan", 32'(bus.cikan_veri), 32'hABC);

    step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("bitti_total", 32'(bitti_cnt), 32'(push_cnt));
    chk("hata_total", 32'(hata_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
